// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM stage datapath driving a 16-bit external SRAM
//
// Purpose:
//   Sits between the EXE and MEM stage registers. Each load/store becomes two
//   16-bit SRAM phases (low half, then high half) addressed by ALU_result_IN.
//   ready is held low while an access is in flight so the top level can
//   freeze the pipeline with freeze = ~ready.
//
// Parameters:
//   ADDR_BASE  byte address mapped to SRAM word 0
//   SRAM_WAIT  cycles per 16-bit SRAM phase (>= 1)
//
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   WB_EN_IN, MEM_R_EN_IN,
//   MEM_W_EN_IN                     control from the EXE stage register
//   ALU_result_IN, Val_Rm_IN,
//   Dest_IN, PC_IN                  address/result, store data, dest, PC
//   WB_EN, MEM_R_EN, ALU_result,
//   PC, Dest                        combinational pass-through
//   MEM_read_value                  registered 32-bit load data
//   ready                           0 = stall pipeline
//   SRAM_ADDR, SRAM_DQ, SRAM_WE_N   external SRAM interface
//
// Optional feature macro: MEM_ACCESS_CNT_EN
//   Adds rd_count/wr_count outputs counting completed reads and writes.

module mem_stage_sram_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter int unsigned SRAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic [31:0] ALU_result_IN,
  input  logic [31:0] Val_Rm_IN,
  input  logic [3:0]  Dest_IN,
  input  logic [31:0] PC_IN,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic [31:0] ALU_result,
  output logic [31:0] PC,
  output logic [3:0]  Dest,
  output logic [31:0] MEM_read_value,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int CNT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [17:0]      addr_q, addr_d;
  logic             we_n_q, we_n_d;
  logic             wr_q, wr_d;       // current access is a write
  logic [15:0]      lo_q, lo_d;       // low half captured during a read
  logic [31:0]      rdata_q, rdata_d;

  logic             req;
  logic             cnt_last;
  logic [16:0]      word_addr;

  // Pass-through to the MEM stage register
  assign WB_EN      = WB_EN_IN;
  assign MEM_R_EN   = MEM_R_EN_IN;
  assign ALU_result = ALU_result_IN;
  assign PC         = PC_IN;
  assign Dest       = Dest_IN;

  assign req      = MEM_R_EN_IN | MEM_W_EN_IN;
  assign cnt_last = (cnt_q == CNT_LAST);

  // Only offset bits [18:2] matter, so the subtraction is done on the low
  // 19 bits; modular arithmetic keeps the wrap behaviour of the full width.
  assign word_addr = 17'((ALU_result_IN[18:0] - ADDR_BASE[18:0]) >> 2);

  assign MEM_read_value = rdata_q;
  assign SRAM_ADDR      = addr_q;
  assign SRAM_WE_N      = we_n_q;

  // we_n_q is low only in LO/HI of a write, so it doubles as output enable
  assign SRAM_DQ = (!we_n_q) ? ((state_q == HI) ? Val_Rm_IN[31:16] : Val_Rm_IN[15:0])
                             : 16'bz;

  // Stall in IDLE is combinational so the request's first cycle is frozen
  assign ready = (!rst) ? 1'b1
               : !((state_q == LO) || (state_q == HI) || ((state_q == IDLE) && req));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_n_d  = 1'b1;
    wr_d    = wr_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LO;
          cnt_d   = '0;
          wr_d    = MEM_W_EN_IN;          // write wins when both are set
          addr_d  = {word_addr, 1'b0};
          we_n_d  = ~MEM_W_EN_IN;
        end
      end
      LO: begin
        we_n_d = ~wr_q;
        if (cnt_last) begin
          state_d = HI;
          cnt_d   = '0;
          addr_d  = {word_addr, 1'b1};
          if (!wr_q) lo_d = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HI: begin
        we_n_d = ~wr_q;
        if (cnt_last) begin
          state_d = DONE;
          cnt_d   = '0;
          we_n_d  = 1'b1;
          if (!wr_q) rdata_d = {SRAM_DQ, lo_q};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Request retires here; IDLE samples the next instruction next cycle
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      wr_q    <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
      wr_q    <= wr_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] rd_count_q, wr_count_q;

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state_q == DONE) begin
      if (wr_q) wr_count_q <= wr_count_q + 32'd1;
      else      rd_count_q <= rd_count_q + 32'd1;
    end
  end
`endif

endmodule
